// File: rtl/video_fetch_pkg.sv
// Shared types and default 800x600 mode constants for the video line fetcher.
package video_fetch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_RECV  = 3'd2,
        ST_READY = 3'd3,
        ST_DRAIN = 3'd4
    } fetch_state_e;

    localparam int H_ACTIVE_DEF    = 800;
    localparam int V_ACTIVE_DEF    = 600;
    localparam int BURST_DEF       = 32;
    localparam int LINE_STRIDE_DEF = 1024;
    localparam int ADDR_W_DEF      = 24;
    localparam int PIX_W_DEF       = 24;

    // Width of the pixel x coordinate inside one line buffer bank.
    localparam int X_W_DEF = $clog2(H_ACTIVE_DEF);

endpackage

// File: rtl/fetch_addr_gen.sv
// Line/burst counters and the frame-store burst address
// (base + line*LINE_STRIDE + burst*BURST, wrapping in ADDR_W bits).
module fetch_addr_gen
    import video_fetch_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int H_ACTIVE    = H_ACTIVE_DEF,
    parameter int V_ACTIVE    = V_ACTIVE_DEF,
    parameter int BURST       = BURST_DEF,
    parameter int LINE_STRIDE = LINE_STRIDE_DEF,
    parameter int NB          = H_ACTIVE / BURST,
    parameter int BW          = (NB > 1) ? $clog2(NB) : 1,
    parameter int LW          = $clog2(V_ACTIVE + 1)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic              burst_inc_i,
    input  logic              burst_clr_i,
    input  logic              line_inc_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic [BW-1:0]     burst_idx_o,
    output logic              last_burst_o,
    output logic              last_line_o
);

    logic [ADDR_W-1:0] base_q, base_d;
    logic [LW-1:0]     line_q, line_d;
    logic [BW-1:0]     burst_q, burst_d;

    // Next-state: a frame load overrides any counter step in the same cycle.
    always_comb begin
        base_d  = base_q;
        line_d  = line_q;
        burst_d = burst_q;
        if (load_i) begin
            base_d  = base_i;
            line_d  = '0;
            burst_d = '0;
        end else begin
            if (burst_clr_i) begin
                burst_d = '0;
            end else if (burst_inc_i) begin
                burst_d = burst_q + 1'b1;
            end
            if (line_inc_i) begin
                line_d = line_q + 1'b1;
            end
        end
    end

    // Counter and base registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            base_q  <= '0;
            line_q  <= '0;
            burst_q <= '0;
        end else begin
            base_q  <= base_d;
            line_q  <= line_d;
            burst_q <= burst_d;
        end
    end

    assign addr_o = base_q
                  + ADDR_W'(line_q) * ADDR_W'(LINE_STRIDE)
                  + ADDR_W'(burst_q) * ADDR_W'(BURST);
    assign burst_idx_o  = burst_q;
    assign last_burst_o = (burst_q == BW'(NB - 1));
    assign last_line_o  = (line_q == LW'(V_ACTIVE - 1));

endmodule

// File: rtl/video_line_fetch_ctrl.sv
// Line-fetch scheduler: prefetches each active line in bursts into the fill
// bank of a ping-pong line buffer, swaps banks on line_start, flags underruns.
// Optional feature macro: LINE_FETCH_STATS_EN adds the saturating underrun_cnt.
// Handshake: mem_req is held with a stable mem_addr until a cycle where
// mem_req and mem_gnt are both high; exactly BURST rd_valid words then follow,
// and only one burst is ever outstanding.
module video_line_fetch_ctrl
    import video_fetch_pkg::*;
#(
    parameter int H_ACTIVE    = H_ACTIVE_DEF,
    parameter int V_ACTIVE    = V_ACTIVE_DEF,
    parameter int BURST       = BURST_DEF,
    parameter int LINE_STRIDE = LINE_STRIDE_DEF,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int PIX_W       = PIX_W_DEF,
    parameter int XW          = $clog2(H_ACTIVE)
) (
    input  logic              clock_pixel,
    input  logic              rst_n,
    input  logic              frame_start,
    input  logic              line_start,
    input  logic [ADDR_W-1:0] frame_base,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              rd_valid,
    input  logic [PIX_W-1:0]  rd_data,
    output logic              buf_wr_en,
    output logic [XW:0]       buf_wr_addr,
    output logic [PIX_W-1:0]  buf_wr_data,
    output logic              disp_bank,
    output logic              busy,
    output logic              underrun,
`ifdef LINE_FETCH_STATS_EN
    output logic [15:0]       underrun_cnt,
`endif
    output fetch_state_e      dbg_state
);

    localparam int NB   = H_ACTIVE / BURST;
    localparam int BW   = (NB > 1) ? $clog2(NB) : 1;
    localparam int WC_W = (BURST > 1) ? $clog2(BURST) : 1;
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(BURST - 1);

    fetch_state_e      state_q, state_d;
    logic [WC_W-1:0]   wcnt_q, wcnt_d;
    logic              mem_req_q, mem_req_d;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              wr_en_q, wr_en_d;
    logic [XW:0]       wr_addr_q;
    logic [PIX_W-1:0]  wr_data_q;
    logic              disp_q, busy_q, underrun_q;

    logic              load, burst_inc, burst_clr, line_inc, toggle, urun_evt;
    logic [ADDR_W-1:0] gen_addr;
    logic [BW-1:0]     burst_idx;
    logic              last_burst, last_line;
    logic              ls, word_last;
    logic [XW-1:0]     x_cur;

    // A frame_start in the same cycle always masks line_start.
    assign ls        = line_start && !frame_start;
    assign word_last = rd_valid && (wcnt_q == WC_LAST);
    assign x_cur     = XW'(burst_idx) * XW'(BURST) + XW'(wcnt_q);

    fetch_addr_gen #(
        .ADDR_W     (ADDR_W),
        .H_ACTIVE   (H_ACTIVE),
        .V_ACTIVE   (V_ACTIVE),
        .BURST      (BURST),
        .LINE_STRIDE(LINE_STRIDE)
    ) u_addr_gen (
        .clk_i       (clock_pixel),
        .rst_ni      (rst_n),
        .load_i      (load),
        .base_i      (frame_base),
        .burst_inc_i (burst_inc),
        .burst_clr_i (burst_clr),
        .line_inc_i  (line_inc),
        .addr_o      (gen_addr),
        .burst_idx_o (burst_idx),
        .last_burst_o(last_burst),
        .last_line_o (last_line)
    );

    // Next-state and control decode for the fetch FSM.
    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        mem_req_d = 1'b0;
        wr_en_d   = 1'b0;
        load      = 1'b0;
        burst_inc = 1'b0;
        burst_clr = 1'b0;
        line_inc  = 1'b0;
        toggle    = 1'b0;
        urun_evt  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
                    load    = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                urun_evt  = ls;
                mem_req_d = 1'b1;
                if (mem_req_q && mem_gnt) begin
                    mem_req_d = 1'b0;
                    wcnt_d    = '0;
                    state_d   = ST_RECV;
                end
                if (frame_start) begin
                    // A burst granted in this very cycle will still return
                    // its words, so they must be drained before restarting.
                    load      = 1'b1;
                    mem_req_d = 1'b0;
                    state_d   = (mem_req_q && mem_gnt) ? ST_DRAIN : ST_REQ;
                end
            end
            ST_RECV: begin
                urun_evt = ls;
                if (rd_valid) begin
                    wr_en_d = !frame_start;
                    wcnt_d  = wcnt_q + 1'b1;
                    if (word_last) begin
                        wcnt_d = '0;
                        if (last_burst) begin
                            burst_clr = 1'b1;
                            state_d   = ST_READY;
                        end else begin
                            burst_inc = 1'b1;
                            state_d   = ST_REQ;
                        end
                    end
                end
                if (frame_start) begin
                    load    = 1'b1;
                    state_d = word_last ? ST_REQ : ST_DRAIN;
                end
            end
            ST_READY: begin
                if (frame_start) begin
                    load    = 1'b1;
                    state_d = ST_REQ;
                end else if (ls) begin
                    toggle   = 1'b1;
                    line_inc = 1'b1;
                    state_d  = last_line ? ST_IDLE : ST_REQ;
                end
            end
            ST_DRAIN: begin
                if (rd_valid) begin
                    wcnt_d = wcnt_q + 1'b1;
                    if (word_last) begin
                        wcnt_d  = '0;
                        state_d = ST_REQ;
                    end
                end
                if (frame_start) begin
                    load = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state and word counter registers.
    always_ff @(posedge clock_pixel) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
        end
    end

    // Registered outputs: request, buffer write port, bank, busy, underrun.
    always_ff @(posedge clock_pixel) begin
        if (!rst_n) begin
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            disp_q     <= 1'b0;
            busy_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            mem_req_q <= mem_req_d;
            if (state_q == ST_REQ) begin
                mem_addr_q <= gen_addr;
            end
            wr_en_q <= wr_en_d;
            if (wr_en_d) begin
                wr_addr_q <= {~disp_q, x_cur};
                wr_data_q <= rd_data;
            end
            if (toggle) begin
                disp_q <= ~disp_q;
            end
            busy_q <= (state_q == ST_REQ) || (state_q == ST_RECV);
            if (urun_evt) begin
                underrun_q <= 1'b1;
            end
        end
    end

`ifdef LINE_FETCH_STATS_EN
    logic [15:0] ucnt_q;

    // Saturating count of underrun events.
    always_ff @(posedge clock_pixel) begin
        if (!rst_n) begin
            ucnt_q <= '0;
        end else if (urun_evt && (ucnt_q != 16'hFFFF)) begin
            ucnt_q <= ucnt_q + 16'd1;
        end
    end

    assign underrun_cnt = ucnt_q;
`endif

    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;
    assign buf_wr_en   = wr_en_q;
    assign buf_wr_addr = wr_addr_q;
    assign buf_wr_data = wr_data_q;
    assign disp_bank   = disp_q;
    assign busy        = busy_q;
    assign underrun    = underrun_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_video_line_fetch_ctrl.sv
// Bench for video_line_fetch_ctrl: table of frame scenarios, a memory
// responder with random data and gaps, and a spec-level line/bank model.
module tb_video_line_fetch_ctrl;
  import video_fetch_pkg::*;

  localparam int H      = 800;
  localparam int B      = 32;
  localparam int NBUR   = H / B;
  localparam int STRIDE = 1024;
  localparam int V_LINES = 4;
  localparam int XW     = 10;
  localparam int W      = 1 + XW + 24;

  logic        clock_pixel;
  logic        rst_n;
  logic        frame_start;
  logic        line_start;
  logic [23:0] frame_base;
  logic        mem_req;
  logic [23:0] mem_addr;
  logic        mem_gnt;
  logic        rd_valid;
  logic [23:0] rd_data;
  logic        buf_wr_en;
  logic [XW:0] buf_wr_addr;
  logic [23:0] buf_wr_data;
  logic        disp_bank;
  logic        busy;
  logic        underrun;
`ifdef LINE_FETCH_STATS_EN
  logic [15:0] underrun_cnt;
`endif
  fetch_state_e dbg_state;

  video_line_fetch_ctrl #(.V_ACTIVE(V_LINES)) dut (
    .clock_pixel (clock_pixel),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .line_start  (line_start),
    .frame_base  (frame_base),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_gnt     (mem_gnt),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .buf_wr_en   (buf_wr_en),
    .buf_wr_addr (buf_wr_addr),
    .buf_wr_data (buf_wr_data),
    .disp_bank   (disp_bank),
    .busy        (busy),
    .underrun    (underrun),
`ifdef LINE_FETCH_STATS_EN
    .underrun_cnt(underrun_cnt),
`endif
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clock_pixel = 1'b0;
  always #5 clock_pixel = ~clock_pixel;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int failures = 0;
  int wr_seen = 0;
  logic [W-1:0] exp_q[$];

  // spec-level model of the display side
  logic [23:0] m_base;
  int          m_line;
  logic        m_disp;
  logic        m_ready;
  logic        m_fetching;
  logic        m_underrun;
  logic [15:0] m_ucnt;
  logic [23:0] first_addr;
  logic [23:0] last_addr;

  typedef struct {
    logic [23:0] base;
    int          gnt_dly;
    int          gap_max;
    logic [23:0] exp_last_l0;
    logic [23:0] exp_first_l1;
  } vec_t;
  vec_t vecs[3];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // write monitor: every buffer write must match the oldest expected word
  always @(negedge clock_pixel) begin
    if (rst_n && buf_wr_en) begin
      wr_seen++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write actual=%0h expected=none (t=%0t)",
                 {buf_wr_addr, buf_wr_data}, $time);
      end else begin
        chk("buf_write", {buf_wr_addr, buf_wr_data}, exp_q.pop_front());
      end
    end
  end

  // watchdog
  initial begin
    repeat (90000) @(posedge clock_pixel);
    failures++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // ---------------- model ----------------
  task automatic model_line_start();
    if (m_ready) begin
      m_disp  = ~m_disp;
      m_ready = 1'b0;
      m_line++;
      if (m_line >= V_LINES) m_fetching = 1'b0;
    end else if (m_fetching) begin
      m_underrun = 1'b1;
      if (m_ucnt != 16'hFFFF) m_ucnt++;
    end
  endtask

  task automatic chk_status(input string tag);
    chk({tag, "_disp_bank"}, disp_bank, m_disp);
    chk({tag, "_underrun"}, underrun, m_underrun);
`ifdef LINE_FETCH_STATS_EN
    chk({tag, "_underrun_cnt"}, underrun_cnt, m_ucnt);
`endif
  endtask

  // ---------------- driver tasks ----------------
  task automatic start_frame(input logic [23:0] base);
    frame_start = 1'b1;
    frame_base  = base;
    @(negedge clock_pixel);
    frame_start = 1'b0;
    m_base = base;
    m_line = 0;
    m_ready = 1'b0;
    m_fetching = 1'b1;
    chk("frame_start_state", dbg_state, ST_REQ);
  endtask

  task automatic pulse_line_start(input string tag);
    line_start = 1'b1;
    @(negedge clock_pixel);
    line_start = 1'b0;
    model_line_start();
    chk_status(tag);
  endtask

  task automatic wait_req(output bit ok);
    int t;
    t = 0;
    while (!mem_req && t < 200) begin
      @(negedge clock_pixel);
      t++;
    end
    ok = mem_req;
    if (!ok) chk("req_timeout", 0, 1);
  endtask

  task automatic serve_burst(input logic [23:0] exp_addr, input int dly, input int gap_max,
                             input logic bank, input int x0, input int ls_word);
    bit ok;
    bit hold_ok;
    logic [23:0] d;
    logic [XW-1:0] xv;
    wait_req(ok);
    if (!ok) return;
    hold_ok = 1'b1;
    for (int i = 0; i < dly; i++) begin
      @(negedge clock_pixel);
      if (!mem_req || mem_addr !== exp_addr) hold_ok = 1'b0;
    end
    if (dly > 0) chk("req_hold", hold_ok, 1);
    chk("req_addr", mem_addr, exp_addr);
    chk("busy_in_req", busy, 1);
    last_addr = mem_addr;
    mem_gnt = 1'b1;
    @(negedge clock_pixel);
    mem_gnt = 1'b0;
    chk("req_drop", mem_req, 0);
    for (int w = 0; w < B; w++) begin
      rd_valid = 1'b0;
      repeat ($urandom_range(0, gap_max)) @(negedge clock_pixel);
      d = 24'($urandom);
      xv = XW'(x0 + w);
      rd_valid = 1'b1;
      rd_data = d;
      line_start = (w == ls_word);
      exp_q.push_back({bank, xv, d});
      @(negedge clock_pixel);
      if (line_start) begin
        line_start = 1'b0;
        model_line_start();
        chk_status("ls_in_recv");
      end
    end
    rd_valid = 1'b0;
  endtask

  task automatic serve_line(input int line, input int first_dly, input int gap_max,
                            input int ls_burst, input int ls_word);
    logic bank;
    logic [23:0] a;
    bank = ~m_disp;
    for (int b = 0; b < NBUR; b++) begin
      a = m_base + 24'(line * STRIDE) + 24'(b * B);
      serve_burst(a, (b == 0) ? first_dly : 0, gap_max, bank, b * B,
                  (b == ls_burst) ? ls_word : -1);
      if (b == 0) first_addr = last_addr;
    end
    @(negedge clock_pixel);
    m_ready = 1'b1;
    chk("line_ready_state", dbg_state, ST_READY);
    chk("line_ready_busy", busy, 0);
    chk("line_all_written", exp_q.size(), 0);
  endtask

  task automatic idle_window(input string name, input int n);
    int seen;
    seen = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clock_pixel);
      if (mem_req) seen++;
    end
    chk(name, seen, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int snap;
    bit ok;
    vecs[0] = '{24'h010000, 0, 0, 24'h010300, 24'h010400};
    vecs[1] = '{24'hFFFF00, 2, 1, 24'h000200, 24'h000300};
    vecs[2] = '{24'h123400, 1, 3, 24'h123700, 24'h123800};

    rst_n = 1'b0; frame_start = 1'b0; line_start = 1'b0; frame_base = '0;
    mem_gnt = 1'b0; rd_valid = 1'b0; rd_data = '0;
    m_base = '0; m_line = 0; m_disp = 1'b0; m_ready = 1'b0; m_fetching = 1'b0;
    m_underrun = 1'b0; m_ucnt = '0; first_addr = '0; last_addr = '0;
    repeat (4) @(negedge clock_pixel);
    rst_n = 1'b1;
    @(negedge clock_pixel);

    // reset state
    chk("reset_outputs", {mem_req, mem_addr, buf_wr_en, buf_wr_addr, buf_wr_data,
                          disp_bank, busy, underrun}, '0);
    chk("reset_state", dbg_state, ST_IDLE);
`ifdef LINE_FETCH_STATS_EN
    chk("reset_underrun_cnt", underrun_cnt, 0);
`endif
    idle_window("reset_no_req", 100);
    pulse_line_start("ls_in_idle");

    // table-driven full frames
    for (int v = 0; v < 3; v++) begin
      start_frame(vecs[v].base);
      serve_line(0, vecs[v].gnt_dly, vecs[v].gap_max, -1, -1);
      chk("l0_first_addr", first_addr, vecs[v].base);
      chk("l0_last_addr", last_addr, vecs[v].exp_last_l0);
      for (int l = 1; l < V_LINES; l++) begin
        pulse_line_start("ls_ready");
        serve_line(l, vecs[v].gnt_dly, vecs[v].gap_max, -1, -1);
        if (l == 1) chk("l1_first_addr", first_addr, vecs[v].exp_first_l1);
      end
      pulse_line_start("ls_last");
      chk("frame_end_idle", dbg_state, ST_IDLE);
      idle_window("frame_end_no_req", 50);
    end

    // frame_start and line_start together while READY, then restart in REQ
    start_frame(24'h200000);
    serve_line(0, 0, 0, -1, -1);
    frame_start = 1'b1; line_start = 1'b1; frame_base = 24'h300000;
    @(negedge clock_pixel);
    frame_start = 1'b0; line_start = 1'b0;
    m_base = 24'h300000; m_line = 0; m_ready = 1'b0;
    chk_status("coincident");
    chk("coincident_state", dbg_state, ST_REQ);
    wait_req(ok);
    chk("coincident_addr", mem_addr, 24'h300000);
    frame_start = 1'b1; frame_base = 24'h340000;
    @(negedge clock_pixel);
    frame_start = 1'b0;
    m_base = 24'h340000;
    chk("req_restart_drop", mem_req, 0);
    serve_line(0, 0, 0, -1, -1);
    chk("req_restart_addr", first_addr, 24'h340000);

    // stalled grant, line_start mid-burst, then line_start on the final word
    start_frame(24'h400000);
    serve_line(0, 3000, 0, 0, 5);
    pulse_line_start("after_underrun");
    serve_line(1, 0, 0, NBUR - 1, B - 1);
    pulse_line_start("after_late_line");
    serve_line(2, 0, 0, -1, -1);

    // frame_start mid-burst: remaining words are drained without writes
    start_frame(24'h500000);
    wait_req(ok);
    chk("drain_first_addr", mem_addr, 24'h500000);
    mem_gnt = 1'b1;
    @(negedge clock_pixel);
    mem_gnt = 1'b0;
    for (int w = 0; w < 10; w++) begin
      rd_valid = 1'b1;
      rd_data = 24'($urandom);
      exp_q.push_back({~m_disp, XW'(w), rd_data});
      @(negedge clock_pixel);
    end
    rd_valid = 1'b0;
    frame_start = 1'b1; frame_base = 24'h600000;
    @(negedge clock_pixel);
    frame_start = 1'b0;
    m_base = 24'h600000; m_line = 0; m_ready = 1'b0;
    snap = wr_seen;
    chk("drain_state", dbg_state, ST_DRAIN);
    for (int w = 0; w < 22; w++) begin
      rd_valid = 1'b1;
      rd_data = 24'($urandom);
      @(negedge clock_pixel);
    end
    rd_valid = 1'b0;
    repeat (2) @(negedge clock_pixel);
    chk("drain_no_write", wr_seen - snap, 0);
    serve_line(0, 0, 0, -1, -1);
    chk("drain_next_addr", first_addr, 24'h600000);
    chk_status("final");

    chk("final_queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/video_line_fetch_ctrl.md
# video_line_fetch_ctrl

Line-fetch scheduler between the frame store's memory read port and the HDMI output path. It prefetches each active video line in fixed-length bursts into a ping-pong line buffer and swaps banks at each line start. The HDMI timing generator's pixel requests then see a complete line. It also detects and reports underruns when a line is not ready in time.

## Interface
- H_ACTIVE, 800: active pixels per line; must be a multiple of BURST.
- V_ACTIVE, 600: active lines per frame.
- BURST, 32: words per memory read grant.
- LINE_STRIDE, 1024: address step between lines, in words.
- ADDR_W, 24: memory address width.
- PIX_W, 24: pixel word width ({R,G,B}).

- clock_pixel  in  1  pixel clock; all logic on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- frame_start  in  1  one-cycle pulse at the start of vertical back porch.
- line_start  in  1  one-cycle pulse, one line period before each active line is displayed.
- frame_base  in  ADDR_W  frame-store base address; sampled on frame_start.
- mem_req  out  1  burst read request.
- mem_addr  out  ADDR_W  burst start address.
- mem_gnt  in  1  request accepted.
- rd_valid  in  1  read data word valid.
- rd_data  in  PIX_W  read data word.
- buf_wr_en  out  1  line-buffer write strobe.
- buf_wr_addr  out  1+clog2(H_ACTIVE)  {fill bank, x}.
- buf_wr_data  out  PIX_W  pixel to write.
- disp_bank  out  1  bank the display side reads; fill bank is always ~disp_bank.
- busy  out  1  fetch in progress (REQ or RECV).
- underrun  out  1  sticky underrun flag; cleared only by reset.
- underrun_cnt  out  16  saturating underrun count (LINE_FETCH_STATS_EN only).

## Operation
- FSM states: IDLE, REQ, RECV, READY, DRAIN.
- Reset: state IDLE. All outputs 0. line_idx = 0, burst_idx = 0, base = 0.
- frame_start from IDLE or READY:
  - base <= frame_base; line_idx <= 0; burst_idx <= 0.
  - Go to REQ; line 0 is fetched into bank ~disp_bank.
- frame_start during REQ: mem_req drops, then REQ restarts for line 0 with the new base.
- frame_start during RECV: go to DRAIN.
  - DRAIN discards the remaining words of the current burst, with buf_wr_en suppressed.
  - Then go to REQ for line 0.
- REQ behaviour:
  - mem_req = 1 with mem_addr = base + line_idx*LINE_STRIDE + burst_idx*BURST, held stable until mem_gnt.
  - On mem_gnt, go to RECV.
- RECV accepts exactly BURST rd_valid words; x = burst_idx*BURST + word count.
- After the last word of a burst:
  - If burst_idx < H_ACTIVE/BURST-1: burst_idx++, go to REQ. Only one burst is ever outstanding.
  - Otherwise: burst_idx <= 0, go to READY.
- line_start in READY:
  - disp_bank toggles; line_idx++.
  - If line_idx+1 < V_ACTIVE, go to REQ; otherwise go to IDLE.
- line_start in REQ or RECV (line not ready) is an underrun:
  - underrun <= 1; disp_bank does not toggle, so the display repeats the previous line.
  - The fetch continues.
  - The missed line_start is not queued; the late line is shown at the next line_start.
- line_start in IDLE or DRAIN: ignored.
- frame_start and line_start in the same cycle: frame_start wins; line_start is ignored.
- Address arithmetic is computed in ADDR_W bits and wraps modulo 2^ADDR_W.

## Timing
- mem_req rises in the cycle after REQ is entered.
- mem_req falls in the cycle after the cycle where mem_gnt = 1 is sampled.
- buf_wr_en/addr/data are registered: they appear one cycle after the matching rd_valid.
- A line is complete (READY) in the cycle after its final rd_valid. A line_start coincident with that final rd_valid is an underrun.
- disp_bank toggles one cycle after line_start.
- busy is registered and follows the state with one cycle of latency.

## Configuration
- LINE_FETCH_STATS_EN defined:
  - underrun_cnt increments on every underrun event and saturates at 16'hFFFF.
  - It is reset to 0 by rst_n.
- LINE_FETCH_STATS_EN undefined:
  - underrun_cnt port is absent; only the sticky underrun flag exists.

## Structure
- Package video_fetch_pkg holds:
  - the FSM state enum;
  - default H_ACTIVE, V_ACTIVE, BURST and LINE_STRIDE constants (800x600 mode);
  - the clog2-derived x width.
- Sub-module fetch_addr_gen holds the line_idx/burst_idx counters and the base + line*stride + burst*BURST address add.
- The FSM, word counter, bank logic and underrun logic stay in the top module.

## Test plan
- Reset with inputs idle:
  - All outputs are 0 and state is IDLE.
  - No mem_req for 100 cycles.
- frame_start with frame_base = 0x010000, mem_gnt granted immediately, data returned back-to-back:
  - 25 requests at 0x010000, 0x010020 … 0x010300.
  - 800 writes to bank 1 with x 0..799.
  - Then READY.
- line_start after READY:
  - disp_bank goes to 1 one cycle later.
  - Next mem_addr = 0x010400 (line 1).
  - After 600 line_starts the FSM is IDLE with no further mem_req.
- mem_gnt stalled 3000 cycles, line_start during RECV:
  - underrun = 1 and disp_bank unchanged.
  - With LINE_FETCH_STATS_EN, underrun_cnt = 1.
  - Fetch completes and the next line_start toggles disp_bank.
- frame_start mid-burst (word 10 of 32):
  - The remaining 22 words produce no buf_wr_en.
  - Next mem_addr = new frame_base.
- frame_start and line_start in the same cycle while READY:
  - Only the frame restart occurs; disp_bank does not toggle and there is no underrun.
